// File: rtl/rej_ntt_sampler_pkg.sv
// Shared definitions for the RejNTTPoly sampler.
// Holds the modulus, polynomial size, SHAKE128 rate geometry, the coefficient
// width and the sampler FSM state encoding.
package rej_ntt_sampler_pkg;

  localparam int unsigned Q          = 8380417;
  localparam int unsigned N_COEF     = 256;
  localparam int unsigned RATE_BYTES = 168;
  localparam int unsigned GROUPS     = RATE_BYTES / 3;   // 56 three-byte groups
  localparam int unsigned RATE_BITS  = RATE_BYTES * 8;   // 1344
  localparam int unsigned COEF_W     = 23;
  localparam int unsigned CNT_W      = 9;                // counts 0..256
  localparam int unsigned GRP_W      = 6;                // counts 0..56

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    SAMPLE   = 2'd2,
    FINISH   = 2'd3
  } state_t;

endpackage

// File: rtl/rej_cand_check.sv
// Candidate extraction and acceptance test for one three-byte group.
// Ports:
//   i_b0, i_b1, i_b2 : bytes 3g, 3g+1, 3g+2 of the current block
//   o_cand           : 23-bit candidate {b2[6:0], b1, b0}
//   o_accept         : high when the candidate is below the modulus
module rej_cand_check
  import rej_ntt_sampler_pkg::*;
(
  input  logic [7:0]        i_b0,
  input  logic [7:0]        i_b1,
  input  logic [7:0]        i_b2,
  output logic [COEF_W-1:0] o_cand,
  output logic              o_accept
);

  // The top bit of the third byte never contributes to the candidate.
  logic w_unused_msb;
  assign w_unused_msb = i_b2[7];

  assign o_cand   = {i_b2[6:0], i_b1, i_b0};
  assign o_accept = (o_cand < COEF_W'(Q));

endmodule

// File: rtl/rej_ntt_sampler.sv
// RejNTTPoly rejection sampler: consumes SHAKE128 squeeze blocks and writes
// 256 coefficients mod q into a polynomial RAM.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : one-cycle pulse to begin a new polynomial (ignored when busy)
//   keccak_state  : squeezed Keccak state; only the low 1344-bit rate is used
//   blk_valid     : keccak_state holds a fresh block
//   blk_ready     : sampler waiting for a block (transfer on valid && ready)
//   squeeze_req   : one-cycle request for the next squeeze block
//   coef_we       : write strobe for an accepted coefficient
//   coef_addr     : coefficient index 0..255
//   coef_data     : accepted coefficient (< q)
//   busy          : polynomial in progress
//   done          : one-cycle pulse after the final coefficient write
module rej_ntt_sampler
  import rej_ntt_sampler_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1599:0]        keccak_state,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  output logic                 squeeze_req,
  output logic                 coef_we,
  output logic [7:0]           coef_addr,
  output logic [COEF_W-1:0]    coef_data,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_COEF - 1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [RATE_BITS-1:0] r_blk;
  logic [GRP_W-1:0]     r_grp;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_we;
  logic [7:0]           r_addr;
  logic [COEF_W-1:0]    r_data;
  logic                 r_sq;
  logic                 r_busy;
  logic                 r_done;

  logic [COEF_W-1:0]    w_cand;
  logic                 w_accept;
  logic                 w_xfer;
  logic                 w_take;
  logic                 w_last_coef;
  logic                 w_last_grp;
  logic                 w_unused;

  // Capacity portion of the state is never sampled.
  assign w_unused = ^keccak_state[1599:RATE_BITS];

  // The block register shifts down one group per SAMPLE cycle, so the
  // current group always sits in the low 24 bits.
  rej_cand_check u_cand (
    .i_b0     (r_blk[7:0]),
    .i_b1     (r_blk[15:8]),
    .i_b2     (r_blk[23:16]),
    .o_cand   (w_cand),
    .o_accept (w_accept)
  );

  assign w_xfer      = (r_state == WAIT_BLK) && blk_valid;
  assign w_take      = (r_state == SAMPLE) && w_accept;
  assign w_last_coef = w_take && (r_cnt == CNT_LAST);
  assign w_last_grp  = (r_state == SAMPLE) && (r_grp == GRP_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and handshake output
  always_comb begin
    w_state_nxt = r_state;
    blk_ready   = 1'b0;
    case (r_state)
      IDLE:     if (start) w_state_nxt = WAIT_BLK;
      WAIT_BLK: begin
        blk_ready = 1'b1;
        if (blk_valid) w_state_nxt = SAMPLE;
      end
      // Finishing takes priority: a 256th accept on group 55 must not
      // request another block.
      SAMPLE: begin
        if (w_last_coef)     w_state_nxt = FINISH;
        else if (w_last_grp) w_state_nxt = WAIT_BLK;
      end
      FINISH:   w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Sampling datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk  <= '0;
      r_grp  <= '0;
      r_cnt  <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_sq   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_we   <= w_take;
      r_sq   <= w_last_grp && !w_last_coef;
      // done follows the final write by one cycle, when FINISH is left.
      r_done <= (r_state == FINISH);

      if ((r_state == IDLE) && start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
      end else if (r_state == FINISH) begin
        r_busy <= 1'b0;
      end

      if (w_take) begin
        r_addr <= r_cnt[7:0];
        r_data <= w_cand;
        r_cnt  <= r_cnt + CNT_W'(1);
      end

      if (w_xfer) begin
        r_blk <= keccak_state[RATE_BITS-1:0];
        r_grp <= '0;
      end else if (r_state == SAMPLE) begin
        r_blk <= r_blk >> 24;
        r_grp <= r_grp + GRP_W'(1);
      end
    end
  end

  assign coef_we     = r_we;
  assign coef_addr   = r_addr;
  assign coef_data   = r_data;
  assign squeeze_req = r_sq;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_rej_ntt_sampler.sv
module tb_rej_ntt_sampler;

  typedef logic [1343:0] blk_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1599:0] keccak_state;
  logic          blk_valid;
  logic          blk_ready;
  logic          squeeze_req;
  logic          coef_we;
  logic [7:0]    coef_addr;
  logic [22:0]   coef_data;
  logic          busy;
  logic          done;

  rej_ntt_sampler dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .keccak_state (keccak_state),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .squeeze_req  (squeeze_req),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Run observations
  blk_t        blkq[$];
  int unsigned got_addr[$];
  int unsigned got_data[$];
  int          sq_cyc[$];
  int          sq_cnt, done_cnt, blk_used, first_lat, last_we_cyc, done_cyc, xfer_cyc;
  logic        busy_at_done;

  // Reference: walk the blocks byte by byte, accept values below q until 256.
  function automatic void ref_model(input blk_t bl[$], output int unsigned coefs[$], output int nblk);
    blk_t cur;
    int unsigned v;
    coefs = {};
    nblk  = 0;
    for (int i = 0; i < bl.size(); i++) begin
      if (coefs.size() >= 256) break;
      cur = bl[i];
      nblk++;
      for (int g = 0; g < 56; g++) begin
        if (coefs.size() >= 256) break;
        v = cur[24*g +: 8] + 256 * cur[24*g+8 +: 8] + 65536 * (cur[24*g+16 +: 8] % 128);
        if (v < 8380417) coefs.push_back(v);
      end
    end
  endfunction

  // mode 0: zeros, 1: all 0xFF, 2: uniform random, 3: random with many near-q groups
  function automatic blk_t gen_blk(input int mode);
    blk_t        b;
    int unsigned v;
    b = '0;
    for (int g = 0; g < 56; g++) begin
      if (mode == 0)      v = 0;
      else if (mode == 1) v = 32'h00FFFFFF;
      else begin
        v = $urandom() & 32'h00FFFFFF;
        if (mode == 3 && $urandom_range(0, 3) == 0) v = 32'h007FE000 | (v & 32'h00801FFF);
      end
      b[24*g +: 24] = v[23:0];
    end
    return b;
  endfunction

  task automatic drive_run(input bit do_start, input int max_cyc, input int stop_coefs,
                           input int extra_start_at, input bit stall);
    got_addr = {}; got_data = {}; sq_cyc = {};
    sq_cnt = 0; done_cnt = 0; blk_used = 0;
    first_lat = -1; last_we_cyc = -1; done_cyc = -1; xfer_cyc = -1; busy_at_done = 1'bx;
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      start = (c == extra_start_at);
      if (coef_we) begin
        got_addr.push_back(coef_addr);
        got_data.push_back(coef_data);
        if (first_lat < 0 && xfer_cyc >= 0) first_lat = c - xfer_cyc;
        last_we_cyc = c;
      end
      if (squeeze_req) begin
        sq_cnt++;
        sq_cyc.push_back(c);
      end
      if (done) begin
        done_cnt++;
        busy_at_done = busy;
        done_cyc = c;
      end
      blk_valid = 1'b0;
      if (stop_coefs > 0 && got_addr.size() >= stop_coefs) break;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      if (blk_ready && blkq.size() > 0 && !(stall && $urandom_range(0, 2) == 0)) begin
        keccak_state = {{8{$urandom()}}, blkq.pop_front()};
        blk_valid = 1'b1;
        blk_used++;
        if (xfer_cyc < 0) xfer_cyc = c;
      end
    end
    blk_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; blk_valid = 1'b0; keccak_state = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({blk_ready, squeeze_req, coef_we, busy, done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {blk_ready, squeeze_req, coef_we, busy, done});
    end
    n_tests++;
    if (coef_addr !== 8'd0 || coef_data !== 23'd0) begin
      n_fail++; $display("FAIL reset_data: addr %0d data %0d want 0 0", coef_addr, coef_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({blk_ready, busy} !== 2'b00) begin
      n_fail++; $display("FAIL idle_after_reset: ready/busy %b want 00", {blk_ready, busy});
    end
  endtask

  task automatic test_zero_block();
    int unsigned exp[$];
    int nblk;
    blkq = {};
    repeat (6) blkq.push_back(gen_blk(0));
    ref_model(blkq, exp, nblk);
    drive_run(1'b1, 2000, 0, -1, 1'b0);
    n_tests++;
    if (got_data.size() !== exp.size()) begin
      n_fail++; $display("FAIL zero_count: got %0d want %0d", got_data.size(), exp.size());
    end
    for (int i = 0; i < got_data.size() && i < exp.size(); i++) begin
      n_tests++;
      if (got_addr[i] !== i || got_data[i] !== exp[i]) begin
        n_fail++; $display("FAIL zero_coef[%0d]: addr %0d data %0d want %0d %0d", i, got_addr[i], got_data[i], i, exp[i]);
      end
    end
    n_tests++;
    if (sq_cnt !== 4 || blk_used !== 5) begin
      n_fail++; $display("FAIL zero_squeeze: squeezes %0d blocks %0d want 4 5", sq_cnt, blk_used);
    end
    n_tests++;
    if (done_cnt !== 1 || done_cyc - last_we_cyc !== 1 || busy_at_done !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: pulses %0d gap %0d busy %b want 1 1 0", done_cnt, done_cyc - last_we_cyc, busy_at_done);
    end
    n_tests++;
    if (first_lat !== 2) begin
      n_fail++; $display("FAIL zero_latency: got %0d want 2", first_lat);
    end
  endtask

  task automatic test_ff_block();
    blkq = {};
    repeat (3) blkq.push_back(gen_blk(1));
    drive_run(1'b1, 3 * 57 + 10, 0, -1, 1'b0);
    n_tests++;
    if (got_data.size() !== 0 || done_cnt !== 0) begin
      n_fail++; $display("FAIL ff_reject: writes %0d done %0d want 0 0", got_data.size(), done_cnt);
    end
    n_tests++;
    if (sq_cnt !== 3) begin
      n_fail++; $display("FAIL ff_squeeze_count: got %0d want 3", sq_cnt);
    end else begin
      n_tests++;
      if (sq_cyc[1] - sq_cyc[0] !== 57 || sq_cyc[2] - sq_cyc[1] !== 57) begin
        n_fail++; $display("FAIL ff_squeeze_spacing: got %0d %0d want 57 57", sq_cyc[1] - sq_cyc[0], sq_cyc[2] - sq_cyc[1]);
      end
    end
    n_tests++;
    if (busy !== 1'b1 || blk_ready !== 1'b1) begin
      n_fail++; $display("FAIL ff_busy: busy %b ready %b want 1 1", busy, blk_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_boundary();
    int unsigned exp[$];
    int nblk;
    blk_t b;
    blkq = {};
    b = gen_blk(2);
    b[23:0]  = 24'h7FE000;   // bytes 00 E0 7F -> 8380416
    b[47:24] = 24'h7FE001;   // bytes 01 E0 7F -> 8380417
    b[71:48] = 24'hFF0000;   // bytes 00 00 FF -> 8323072 after masking
    blkq.push_back(b);
    repeat (8) blkq.push_back(gen_blk(2));
    ref_model(blkq, exp, nblk);
    drive_run(1'b1, 3000, 0, -1, 1'b0);
    n_tests++;
    if (got_data.size() !== exp.size()) begin
      n_fail++; $display("FAIL bound_count: got %0d want %0d", got_data.size(), exp.size());
    end
    if (got_data.size() >= 2) begin
      n_tests++;
      if (got_data[0] !== 8380416 || got_data[1] !== 8323072) begin
        n_fail++; $display("FAIL bound_values: got %0d %0d want 8380416 8323072", got_data[0], got_data[1]);
      end
    end
    for (int i = 0; i < got_data.size() && i < exp.size(); i++) begin
      n_tests++;
      if (got_addr[i] !== i || got_data[i] !== exp[i]) begin
        n_fail++; $display("FAIL bound_coef[%0d]: addr %0d data %0d want %0d %0d", i, got_addr[i], got_data[i], i, exp[i]);
      end
    end
    n_tests++;
    if (done_cnt !== 1 || sq_cnt !== nblk - 1) begin
      n_fail++; $display("FAIL bound_done: done %0d squeezes %0d want 1 %0d", done_cnt, sq_cnt, nblk - 1);
    end
  endtask

  task automatic test_handshake();
    int bad_idle = 0;
    int bad_wait = 0;
    @(negedge clk);
    keccak_state = {256'd0, gen_blk(0)};
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (coef_we || busy || blk_ready) bad_idle++;
    end
    n_tests++;
    if (bad_idle !== 0) begin
      n_fail++; $display("FAIL idle_valid_ignored: active cycles %0d want 0", bad_idle);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (coef_we || !blk_ready) bad_wait++;
    end
    n_tests++;
    if (bad_wait !== 0) begin
      n_fail++; $display("FAIL wait_hold: bad cycles %0d want 0", bad_wait);
    end
    blkq = {};
    repeat (5) blkq.push_back(gen_blk(0));
    drive_run(1'b0, 2000, 0, -1, 1'b1);
    n_tests++;
    if (got_data.size() !== 256 || done_cnt !== 1) begin
      n_fail++; $display("FAIL hs_complete: writes %0d done %0d want 256 1", got_data.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned exp[$];
    int nblk;
    int bad = 0;
    blkq = {};
    repeat (10) blkq.push_back(gen_blk(2));
    drive_run(1'b1, 2000, 100, -1, 1'b0);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({blk_ready, squeeze_req, coef_we, busy, done} !== 5'b0 || coef_addr !== 8'd0 || coef_data !== 23'd0) begin
      n_fail++; $display("FAIL async_reset: ctrl %b addr %0d data %0d want 0", {blk_ready, squeeze_req, coef_we, busy, done}, coef_addr, coef_data);
    end
    repeat (3) begin
      @(negedge clk);
      if (coef_we || done || squeeze_req) bad++;
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bad !== 0 || coef_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: strobes %0d want 0", bad);
    end
    blkq = {};
    repeat (10) blkq.push_back(gen_blk(3));
    ref_model(blkq, exp, nblk);
    drive_run(1'b1, 3000, 0, -1, 1'b0);
    n_tests++;
    if (got_data.size() !== 256 || done_cnt !== 1) begin
      n_fail++; $display("FAIL restart_count: writes %0d done %0d want 256 1", got_data.size(), done_cnt);
    end
    for (int i = 0; i < got_data.size() && i < exp.size(); i++) begin
      n_tests++;
      if (got_addr[i] !== i || got_data[i] !== exp[i]) begin
        n_fail++; $display("FAIL restart_coef[%0d]: addr %0d data %0d want %0d %0d", i, got_addr[i], got_data[i], i, exp[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int unsigned exp[$];
    int nblk;
    blkq = {};
    repeat (10) blkq.push_back(gen_blk(3));
    ref_model(blkq, exp, nblk);
    drive_run(1'b1, 3000, 0, 40, 1'b0);
    n_tests++;
    if (got_data.size() !== exp.size() || done_cnt !== 1) begin
      n_fail++; $display("FAIL busy_start_count: writes %0d done %0d want %0d 1", got_data.size(), done_cnt, exp.size());
    end
    for (int i = 0; i < got_data.size() && i < exp.size(); i++) begin
      n_tests++;
      if (got_addr[i] !== i || got_data[i] !== exp[i]) begin
        n_fail++; $display("FAIL busy_start_coef[%0d]: addr %0d data %0d want %0d %0d", i, got_addr[i], got_data[i], i, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    int unsigned exp[$];
    int nblk;
    for (int it = 0; it < 3; it++) begin
      blkq = {};
      repeat (14) blkq.push_back(gen_blk(3));
      ref_model(blkq, exp, nblk);
      drive_run(1'b1, 4000, 0, -1, 1'b1);
      n_tests++;
      if (got_data.size() !== exp.size() || done_cnt !== 1 || busy_at_done !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_done: writes %0d done %0d busy %b want %0d 1 0", it, got_data.size(), done_cnt, busy_at_done, exp.size());
      end
      n_tests++;
      if (sq_cnt !== nblk - 1 || blk_used !== nblk) begin
        n_fail++; $display("FAIL rand%0d_blocks: squeezes %0d blocks %0d want %0d %0d", it, sq_cnt, blk_used, nblk - 1, nblk);
      end
      for (int i = 0; i < got_data.size() && i < exp.size(); i++) begin
        n_tests++;
        if (got_addr[i] !== i || got_data[i] !== exp[i]) begin
          n_fail++; $display("FAIL rand%0d_coef[%0d]: addr %0d data %0d want %0d %0d", it, i, got_addr[i], got_data[i], i, exp[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_ff_block();
    test_boundary();
    test_handshake();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rej_ntt_sampler.md
Name: rej_ntt_sampler

Overview:
Consumer end of the ExpandA G-function path. Takes squeezed SHAKE128 states (1600-bit Keccak state; the low 1344-bit rate portion is used) and performs RejNTTPoly rejection sampling to produce 256 coefficients mod q = 8380417. It requests further squeeze blocks from the G-function until 256 coefficients are accepted. Accepted coefficients are written into a polynomial RAM through a write-strobe interface.

Parameters:
Q, 8380417, modulus; a candidate is accepted iff candidate < Q
N_COEF, 256, coefficients per polynomial
RATE_BYTES, 168, SHAKE128 rate in bytes; 56 three-byte groups per block

Ports:
clk  input  1  system clock; all logic rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins sampling a new polynomial
keccak_state  input  1600  squeezed state; byte k = keccak_state[8k+7:8k]
blk_valid  input  1  keccak_state holds a fresh squeeze block
blk_ready  output  1  sampler can take a block; transfer when blk_valid && blk_ready
squeeze_req  output  1  one-cycle pulse requesting the next squeeze permutation
coef_we  output  1  write strobe for an accepted coefficient
coef_addr  output  8  coefficient index, 0..255
coef_data  output  23  accepted coefficient, always < Q
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse after the 256th coefficient is written

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; coefficient counter 0; group counter 0; block register cleared.
- FSM: IDLE -> WAIT_BLK on start. WAIT_BLK -> SAMPLE on the blk_valid && blk_ready transfer. SAMPLE -> WAIT_BLK after group 55 if coefficient count < 256. SAMPLE -> FINISH when the 256th coefficient is accepted. FINISH -> IDLE after one cycle.
- blk_ready = 1 only in WAIT_BLK. On transfer, keccak_state[1343:0] is latched into the block register and the group counter is cleared.
- SAMPLE evaluates one group g per cycle, g = 0..55:
  - b0 = byte 3g, b1 = byte 3g+1, b2 = byte 3g+2.
  - candidate = {b2[6:0], b1, b0}, 23 bits; b2[7] is discarded.
- If candidate < Q, the coefficient is registered. coef_we is high the following cycle, with coef_addr = current count and coef_data = candidate. The count then increments.
- Throughput: at most one coefficient per cycle. The RAM side has no backpressure.
- Latency: the first coef_we can occur 2 cycles after the block transfer.
- Block exhaustion: on leaving SAMPLE after group 55, squeeze_req pulses for 1 cycle together with the transition to WAIT_BLK.
- Early completion: when the 256th accept occurs mid-block, the remaining groups are discarded and no squeeze_req is issued.
- done pulses in FINISH, aligned with the cycle after the final coef_we. busy drops in that same cycle.
- start while busy is ignored.
- blk_valid while not in WAIT_BLK is ignored; no block is latched.
- The first block comes from the G-function start itself, so no squeeze_req is issued before the first block.
- Reset mid-operation: immediate return to IDLE; any partial polynomial is abandoned. No coef_we, done or squeeze_req is asserted during or after reset.
- coef_addr wraps never: the count saturates at 256 and leaves SAMPLE.

Decomposition:
- Shared package: constants Q and N_COEF, RATE_BYTES, an FSM state enum (IDLE, WAIT_BLK, SAMPLE, FINISH), and the coefficient width (23).
- One sub-module, rej_cand_check: combinational extraction of one 23-bit candidate from three bytes, plus the compare against Q (accept flag).

Test Plan:
- All-zero block, presented on every squeeze_req:
  - 56 coef_we per block with data 0.
  - squeeze_req pulses 4 times; the 5th block supplies 32 coefficients.
  - coef_addr runs 0..255, then done pulses once.
- All-0xFF block: every candidate 0x7FFFFF = 8388607 is rejected. No coef_we; squeeze_req after every 56 SAMPLE cycles; busy stays high.
- Boundary groups, bytes (b0,b1,b2):
  - (0x00,0xE0,0x7F) = 8380416 -> accepted, coef_data 8380416.
  - (0x01,0xE0,0x7F) = 8380417 -> rejected.
  - (0x00,0x00,0xFF) -> MSB masked -> 8323072 accepted.
- Handshake: hold blk_valid low for 10 cycles in WAIT_BLK -> no coef_we and blk_ready stays high. A blk_valid pulse in IDLE -> ignored.
- Reset mid-operation: assert rst after 100 coefficients -> outputs 0 asynchronously. A new start then restarts at coef_addr 0, and done follows after exactly 256 coef_we.
- start pulsed while busy -> no effect; the coefficient sequence is identical to a run without the extra start.
